// File: rtl/instr_stream_encoder.sv
// RV32I field packer: turns a stream of field tuples into instruction words
// tagged with sequential instruction-memory addresses, flagging unrepresentable immediates.
module instr_stream_encoder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           format_i,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          addr_o,
    output logic                 err_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     accepted, sent;
    logic [31:0]          next_addr;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 ready, launch, accept, xfer;
    logic [32:0]          enc;

    logic                 vld_p1;
    logic [31:0]          instr_p1;
    logic [31:0]          addr_p1;
    logic                 err_p1;

    // True when v lies in the two's-complement range of a bits-wide field.
    function automatic logic imm_fits(input logic signed [31:0] v, input int bits);
        logic signed [31:0] hi, lo;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    // Returns {err, word}; range errors still emit the truncated word.
    function automatic logic [32:0] encode(
        input logic [2:0]         fmt,
        input logic [6:0]         op,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [31:0] imm
    );
        logic [31:0] w;
        logic        e;
        case (fmt)
            3'd0: begin
                w = {imm[11:0], rs1, f3, rd, op};
                e = !imm_fits(imm, 12);
            end
            3'd1: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e = !imm_fits(imm, 12);
            end
            3'd2: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e = !imm_fits(imm, 13) || imm[0];
            end
            3'd3: begin
                w = {imm[31:12], rd, op};
                e = (imm[11:0] != 12'd0);
            end
            3'd4: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e = !imm_fits(imm, 21) || imm[0];
            end
            3'd5: begin
                w = {f7, rs2, rs1, f3, rd, op};
                e = 1'b0;
            end
            default: begin
                w = 32'd0;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    assign enc    = encode(format_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
    assign xfer   = vld_p1 && out_ready_i;
    assign accept = in_valid_i && ready;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                ready = (!vld_p1 || out_ready_i) && (accepted < DEPTH_C);
                if (xfer && (sent == LAST_C))
                    state_nxt = DONE;
            end
            DONE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            accepted  <= '0;
            sent      <= '0;
            next_addr <= BASE_ADDR;
            err_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                accepted  <= '0;
                sent      <= '0;
                next_addr <= BASE_ADDR;
                err_cnt   <= '0;
            end else begin
                if (accept) begin
                    accepted  <= accepted + ONE_C;
                    next_addr <= next_addr + 32'd4;
                    if (enc[32])
                        err_cnt <= sat_inc(err_cnt);
                end
                if (xfer)
                    sent <= sent + ONE_C;
            end
        end
    end

    // ---- stage p1: output register, reloaded on accept, emptied on bare transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1   <= 1'b0;
            instr_p1 <= 32'd0;
            addr_p1  <= BASE_ADDR;
            err_p1   <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            instr_p1 <= enc[31:0];
            addr_p1  <= next_addr;
            err_p1   <= enc[32];
        end else if (xfer) begin
            vld_p1 <= 1'b0;
        end
    end

    assign in_ready_o  = ready;
    assign out_valid_o = vld_p1;
    assign instr_o     = instr_p1;
    assign addr_o      = addr_p1;
    assign err_o       = err_p1;
    assign done_o      = (state == DONE);
    assign busy_o      = (state == RUN);
    assign err_count_o = err_cnt;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: directed sessions from the test plan
// followed by randomized sessions checked against a field-packing reference model.
module tb_instr_stream_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
    localparam int          ECW   = 2;
    localparam int          EMAX  = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1, start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [2:0]     format_i = '0, funct3_i = '0;
    logic [6:0]     opcode_i = '0, funct7_i = '0;
    logic [4:0]     rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [31:0]    imm_i = '0;
    logic           in_ready_o, out_valid_o, err_o, done_o, busy_o;
    logic [31:0]    instr_o, addr_o;
    logic [ECW-1:0] err_count_o;

    instr_stream_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .format_i(format_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o),
        .done_o(done_o), .busy_o(busy_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        int          ecnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0, fails = 0;
    int   idx = 0, errs = 0, xfers = 0;
    bit   expect_done = 0, rand_ready = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference packing written straight from the field layout, with shifts and masks.
    function automatic void model(input logic [31:0] fmt, op, rd, rs1, rs2, f3, f7, imm,
                                  output logic [31:0] w, output logic e);
        logic signed [31:0] s;
        w = 32'd0;
        e = 1'b0;
        case (fmt)
            0: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                s = $signed(imm) >>> 11;  e = !(s == 0 || s == -1);
            end
            1: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
                s = $signed(imm) >>> 11;  e = !(s == 0 || s == -1);
            end
            2: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | op;
                s = $signed(imm) >>> 12;  e = !(s == 0 || s == -1) || (imm % 2 != 0);
            end
            3: begin
                w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
                e = (imm & 32'hFFF) != 0;
            end
            4: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (rd << 7) | op;
                s = $signed(imm) >>> 20;  e = !(s == 0 || s == -1) || (imm % 2 != 0);
            end
            5: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            default: begin
                w = 32'd0;  e = 1'b1;
            end
        endcase
    endfunction

    task automatic push_expected();
        exp_t x;
        model(32'(format_i), 32'(opcode_i), 32'(rd_i), 32'(rs1_i), 32'(rs2_i),
              32'(funct3_i), 32'(funct7_i), imm_i, x.instr, x.err);
        if (x.err && errs < EMAX) errs++;
        x.ecnt = errs;
        x.addr = BASE + 32'(4 * idx);
        idx++;
        q.push_back(x);
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        format_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm; in_valid_i = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready_o) begin
                push_expected();
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL accept_timeout: in_ready_o never rose");
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        drive(f, op, rd, rs1, rs2, f3, f7, imm);
        wait_accept();
    endtask

    task automatic start_session();
        @(posedge clk); #1;
        start_i = 1'b1; idx = 0; errs = 0; xfers = 0;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("start_err_count", 32'(err_count_o), 32'd0);
        chk("start_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_o) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL done_timeout: done_o never rose, %0d words pending", q.size());
        end
        @(negedge clk);
        chk("done_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] b[12] = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094,
                               -32'sd4096, 32'd4096, 32'd4095, 32'h000F_FFFE,
                               32'hFFF0_0000, 32'h0010_0000, 32'd1};
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 63)) - 32'd32;
            1: return b[$urandom_range(0, 11)];
            2: return $urandom;
            3: return $urandom << 12;
            4: return ($urandom & 32'h000F_FFFE) | (($urandom % 2) ? 32'hFFF0_0000 : 32'h0);
            default: return (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
        endcase
    endfunction

    // Monitor: every presented word is compared with the queue head; popped on transfer.
    initial forever begin
        @(negedge clk);
        if (expect_done) begin
            expect_done = 0;
            chk("done_after_last", 32'(done_o), 32'd1);
            chk("done_in_ready", 32'(in_ready_o), 32'd0);
            chk("done_out_valid", 32'(out_valid_o), 32'd0);
            chk("done_busy", 32'(busy_o), 32'd0);
        end
        if (!rst_i && out_valid_o) begin
            if (q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_word: instr %h addr %h with nothing expected",
                         instr_o, addr_o);
            end else begin
                chk("instr", instr_o, q[0].instr);
                chk("addr", addr_o, q[0].addr);
                chk("err", 32'(err_o), 32'(q[0].err));
                chk("err_count", 32'(err_count_o), 32'(q[0].ecnt));
                if (out_ready_i) begin
                    void'(q.pop_front());
                    xfers++;
                    if (xfers == DEPTH) expect_done = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
        chk({tag, "_addr"}, addr_o, BASE);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count_o), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        in_valid_i = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;

        // Session 1: test-plan vectors, continuous stream, memory always ready.
        out_ready_i = 1'b1;
        start_session();
        drive(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);          wait_accept();
        drive(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);  wait_accept();
        drive(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);  wait_accept();
        drive(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);        wait_accept();
        wait_done();

        // Session 2: error cases, then back-to-back tuples against a stalled memory.
        start_session();
        send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        send(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        send(3'd0, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, -32'sd7);
        drive(3'd2, 7'h63, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, -32'sd16);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        wait_accept();
        wait_done();

        // Session 3: every tuple invalid, driving the counter into saturation.
        start_session();
        for (int i = 0; i < DEPTH; i++) send(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        wait_done();

        // Reset while a word is held on the output.
        start_session();
        out_ready_i = 1'b0;
        send(3'd3, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        rst_i = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        expect_done = 0;
        @(negedge clk);
        check_reset_values("midrst");
        out_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Randomized sessions with random gaps and memory back-pressure.
        rand_ready = 1;
        for (int s = 0; s < 25; s++) begin
            start_session();
            for (int i = 0; i < DEPTH; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
            end
            wait_done();
        end
        rand_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
